pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Handles the post-reset pipeline scrub, load-use bubbles, taken-branch/jump flushes, instruction-fetch wait and data-memory wait freezes.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/core_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control blocks.
// Holds the hazard FSM state type, the x0 register index and per-stage control bundle.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    LU   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at all-ones once reached until cleared or reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: reset scrub, load-use bubbles,
// branch flushes, fetch-wait and data-wait freezes, plus a stall-cycle counter.
module pipeline_hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int RESET_FLUSH_CYCLES = 2,
  parameter int LU_BUBBLES         = 1,
  parameter int CNT_W              = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_write_en_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             cnt_clr_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_stall_o,
  output logic             memwb_flush_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [2:0] INIT_CNT = 3'(RESET_FLUSH_CYCLES);
  localparam logic [2:0] LU_CNT   = 3'(LU_BUBBLES - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic       hazard;
  logic       freeze;
  logic       branch;
  logic       in_init;
  logic       pc_stall;
  logic       exmem_stall;
  logic       memwb_flush;
  stage_ctl_t ifid_ctl;
  stage_ctl_t idex_ctl;

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign hazard = ex_mem_read_i && ex_reg_write_en_i && (ex_rd_i != REG_X0) &&
                  ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                   (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
  assign freeze  = dmem_req_i && !dmem_ready_i;
  assign branch  = ex_branch_taken_i;
  assign in_init = (state_q == INIT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= INIT;
      cnt_q   <= INIT_CNT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RUN;
      end
      default: begin
        if (freeze) begin
          state_d = state_q;
        end else if (branch) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else if (state_q == LU) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
        end else if (hazard && (LU_BUBBLES > 1)) begin
          state_d = LU;
          cnt_d   = LU_CNT;
        end
      end
    endcase
  end

  // Priority: scrub, data freeze, branch, load-use, fetch wait.
  always_comb begin
    pc_stall    = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    ifid_ctl    = '0;
    idex_ctl    = '0;
    if (in_init) begin
      pc_stall       = 1'b1;
      ifid_ctl.flush = 1'b1;
      idex_ctl.flush = 1'b1;
      memwb_flush    = 1'b1;
    end else if (freeze) begin
      pc_stall       = 1'b1;
      ifid_ctl.stall = 1'b1;
      idex_ctl.stall = 1'b1;
      exmem_stall    = 1'b1;
      memwb_flush    = 1'b1;
    end else if (branch) begin
      ifid_ctl.flush = 1'b1;
      idex_ctl.flush = 1'b1;
    end else if ((state_q == LU) || hazard) begin
      pc_stall       = 1'b1;
      ifid_ctl.stall = 1'b1;
      idex_ctl.flush = 1'b1;
    end else if (!imem_ready_i) begin
      pc_stall       = 1'b1;
      ifid_ctl.flush = 1'b1;
    end
  end

  assign pc_stall_o    = pc_stall;
  assign ifid_stall_o  = ifid_ctl.stall;
  assign ifid_flush_o  = ifid_ctl.flush;
  assign idex_stall_o  = idex_ctl.stall;
  assign idex_flush_o  = idex_ctl.flush;
  assign exmem_stall_o = exmem_stall;
  assign memwb_flush_o = memwb_flush;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (cnt_clr_i),
    .inc_i  (pc_stall && !in_init),
    .cnt_o  (stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random checks of two hazard controller configurations
// against a cycle-level reference model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses1, uses2, ex_we, ex_mem_read, ex_br;
  logic       imem_ready, dmem_req, dmem_ready, cnt_clr;

  logic [6:0]  outv [2];
  logic [31:0] cntv [2];
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  int     vectors = 0;
  int     miscompares = 0;
  string  phase = "reset";

  int     init_left [2];
  int     lu_left   [2];
  longint scnt      [2];
  bit     was_init  [2];
  bit     exp_pc    [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RESET_FLUSH_CYCLES(2), .LU_BUBBLES(3), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .ex_rd_i(ex_rd), .ex_reg_write_en_i(ex_we), .ex_mem_read_i(ex_mem_read),
    .ex_branch_taken_i(ex_br), .imem_ready_i(imem_ready), .dmem_req_i(dmem_req),
    .dmem_ready_i(dmem_ready), .cnt_clr_i(cnt_clr),
    .pc_stall_o(outv[0][6]), .ifid_stall_o(outv[0][5]), .ifid_flush_o(outv[0][4]),
    .idex_stall_o(outv[0][3]), .idex_flush_o(outv[0][2]), .exmem_stall_o(outv[0][1]),
    .memwb_flush_o(outv[0][0]), .stall_cycles_o(cnt_a)
  );

  pipeline_hazard_ctrl #(.RESET_FLUSH_CYCLES(3), .LU_BUBBLES(1), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .ex_rd_i(ex_rd), .ex_reg_write_en_i(ex_we), .ex_mem_read_i(ex_mem_read),
    .ex_branch_taken_i(ex_br), .imem_ready_i(imem_ready), .dmem_req_i(dmem_req),
    .dmem_ready_i(dmem_ready), .cnt_clr_i(cnt_clr),
    .pc_stall_o(outv[1][6]), .ifid_stall_o(outv[1][5]), .ifid_flush_o(outv[1][4]),
    .idex_stall_o(outv[1][3]), .idex_flush_o(outv[1][2]), .exmem_stall_o(outv[1][1]),
    .memwb_flush_o(outv[1][0]), .stall_cycles_o(cnt_b)
  );

  assign cntv[0] = {28'd0, cnt_a};
  assign cntv[1] = cnt_b;

  function automatic int cfg_rfc(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int cfg_lub(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic longint cfg_max(int k);
    return (k == 0) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic bit load_use();
    return ex_mem_read && ex_we && (ex_rd != 5'd0) &&
           ((uses1 && id_rs1 == ex_rd) || (uses2 && id_rs2 == ex_rd));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      init_left[k] = cfg_rfc(k);
      lu_left[k]   = 0;
      scnt[k]      = 0;
    end
  endtask

  // Expected control bits {pc, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, memwb_fl}.
  function automatic logic [6:0] expected(int k);
    if (!rst_n || init_left[k] > 0)          return 7'b1010101;
    if (dmem_req && !dmem_ready)             return 7'b1101011;
    if (ex_br)                               return 7'b0010100;
    if (lu_left[k] > 0 || load_use())        return 7'b1100100;
    if (!imem_ready)                         return 7'b1010000;
    return 7'b0000000;
  endfunction

  task automatic check();
    logic [6:0] ev;
    if (!rst_n) model_reset();
    for (int k = 0; k < 2; k++) begin
      ev = expected(k);
      was_init[k] = (init_left[k] > 0);
      exp_pc[k]   = ev[6];
      vectors++;
      assert (outv[k] === ev) else begin
        miscompares++;
        $error("FAIL %s ctl[%0d] got %b want %b", phase, k, outv[k], ev);
      end
      vectors++;
      assert (cntv[k] === 32'(scnt[k])) else begin
        miscompares++;
        $error("FAIL %s stall_cycles[%0d] got %0d want %0d", phase, k, cntv[k], scnt[k]);
      end
    end
  endtask

  task automatic update();
    bit hz;
    hz = load_use();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (was_init[k])                  init_left[k]--;
      else if (dmem_req && !dmem_ready) ;
      else if (ex_br)                   lu_left[k] = 0;
      else if (lu_left[k] > 0)          lu_left[k]--;
      else if (hz)                      lu_left[k] = cfg_lub(k) - 1;
      if (cnt_clr)                                         scnt[k] = 0;
      else if (exp_pc[k] && !was_init[k] && scnt[k] < cfg_max(k)) scnt[k]++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; uses1 = 1'b0; uses2 = 1'b0;
    ex_rd = 5'd0; ex_we = 1'b0; ex_mem_read = 1'b0; ex_br = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic lw_x5_use(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_we = 1'b1; ex_rd = rd; id_rs1 = rd; uses1 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (5) cycle();

    phase = "loaduse";
    lw_x5_use(5'd5); cycle();
    idle(); repeat (3) cycle();

    phase = "x0";
    lw_x5_use(5'd0); cycle();
    idle(); cycle();

    phase = "br_in_lu";
    lw_x5_use(5'd7); cycle();
    idle(); cycle();
    ex_br = 1'b1; cycle();
    ex_br = 1'b0; repeat (2) cycle();

    phase = "dwait";
    lw_x5_use(5'd9); dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (4) cycle();
    dmem_ready = 1'b1; dmem_req = 1'b0; cycle();
    idle(); repeat (3) cycle();

    phase = "fwait";
    imem_ready = 1'b0; repeat (2) cycle();
    imem_ready = 1'b1; cycle();

    phase = "saturate";
    imem_ready = 1'b0; repeat (20) cycle();
    cnt_clr = 1'b1; cycle();
    cnt_clr = 1'b0; imem_ready = 1'b1; repeat (2) cycle();

    phase = "rst_mid_lu";
    lw_x5_use(5'd3); cycle();
    idle(); rst_n = 1'b0; cycle();
    rst_n = 1'b1; repeat (4) cycle();

    phase = "rst_mid_freeze";
    dmem_req = 1'b1; dmem_ready = 1'b0; cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; idle(); repeat (4) cycle();

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      uses1       = 1'($urandom);
      uses2       = 1'($urandom);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_we       = ($urandom_range(0, 3) != 0);
      ex_mem_read = 1'($urandom);
      ex_br       = ($urandom_range(0, 7) == 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      dmem_req    = 1'($urandom);
      dmem_ready  = ($urandom_range(0, 2) != 0);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
